// File: rtl/port_egress_buffer.sv
// Store-and-forward egress buffer: captures a chunk stream and replays only packets that arrived whole.
// Latency: first chunk of a packet is offered on o_val the cycle after its eop chunk is written.
// Backpressure: none toward the chunk input (overflowing packets are dropped whole); o_rdy stalls replay with o_* held stable.
//
// Ports:
//   clk, reset                  : single clock, synchronous active-high reset
//   i_val/i_sop/i_eop/i_vbc/i_data : incoming 32-byte chunk stream, no backpressure
//   o_val/o_sop/o_eop/o_vbc/o_data : replayed chunks, handshake with o_rdy
//   pkt_cnt, occupancy          : committed packets held / entries in use (uncommitted included)
//   drop_cnt, err_cnt           : saturating statistics, live only when EGRESS_STATS_EN is defined
//
// Build option: define EGRESS_STATS_EN to enable the drop/error counters; otherwise both read 0.

module port_egress_buffer #(
    parameter int DEPTH      = 16,
    parameter int CNT_SIZE_P = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_val,
    input  logic                    i_sop,
    input  logic                    i_eop,
    input  logic [7:0]              i_vbc,
    input  logic [255:0]            i_data,
    output logic                    o_val,
    output logic                    o_sop,
    output logic                    o_eop,
    output logic [7:0]              o_vbc,
    output logic [255:0]            o_data,
    input  logic                    o_rdy,
    output logic [$clog2(DEPTH):0]  pkt_cnt,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [CNT_SIZE_P-1:0]   drop_cnt,
    output logic [CNT_SIZE_P-1:0]   err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_PW = PW'(DEPTH);

    typedef struct packed {
        logic         sop;
        logic         eop;
        logic [7:0]   vbc;
        logic [255:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        DROP   = 2'd2
    } wr_state_t;

    entry_t mem [DEPTH];

    wr_state_t       state, state_nxt;
    logic [PW-1:0]   wr_ptr, wr_ptr_nxt;
    logic [PW-1:0]   wr_cmt, wr_cmt_nxt;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   base;
    logic [PW-1:0]   pkt_cnt_q;
    logic [AW-1:0]   waddr;
    logic            full;
    logic            sop_case;
    logic            we;
    logic            commit;
    logic            drop_inc;
    logic            err_inc;
    logic            rd_fire;
    entry_t          wr_entry;
    entry_t          rd_entry;

    // Full is taken from registered pointers only, so a read this cycle
    // never makes room for this cycle's write.
    assign full     = (wr_ptr - rd_ptr) == DEPTH_PW;
    assign wr_entry = '{sop: i_sop, eop: i_eop, vbc: i_vbc, data: i_data};

    // ------------------------------------------------------------------
    // Write FSM: next state, pointer moves and event flags
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        wr_cmt_nxt = wr_cmt;
        base       = wr_ptr;
        sop_case   = 1'b0;
        we         = 1'b0;
        waddr      = wr_ptr[AW-1:0];
        commit     = 1'b0;
        drop_inc   = 1'b0;
        err_inc    = 1'b0;

        case (state)
            IDLE: begin
                if (i_val) begin
                    if (i_sop) begin
                        sop_case = 1'b1;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            ACCEPT: begin
                if (i_val) begin
                    if (i_sop) begin
                        // Truncated packet: discard it and restart on this sop,
                        // with the space check done against the rewound pointer.
                        err_inc    = 1'b1;
                        base       = wr_cmt;
                        wr_ptr_nxt = wr_cmt;
                        sop_case   = 1'b1;
                    end else if (full) begin
                        wr_ptr_nxt = wr_cmt;
                        drop_inc   = 1'b1;
                        state_nxt  = i_eop ? IDLE : DROP;
                    end else begin
                        we         = 1'b1;
                        wr_ptr_nxt = wr_ptr + PW'(1);
                        if (i_eop) begin
                            wr_cmt_nxt = wr_ptr + PW'(1);
                            commit     = 1'b1;
                            state_nxt  = IDLE;
                        end
                    end
                end
            end
            DROP: begin
                if (i_val) begin
                    if (i_sop) begin
                        err_inc  = 1'b1;
                        sop_case = 1'b1;
                    end else if (i_eop) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Start-of-packet handling shared by all states
        if (sop_case) begin
            if ((base - rd_ptr) == DEPTH_PW) begin
                drop_inc  = 1'b1;
                state_nxt = i_eop ? IDLE : DROP;
            end else begin
                we         = 1'b1;
                waddr      = base[AW-1:0];
                wr_ptr_nxt = base + PW'(1);
                if (i_eop) begin
                    wr_cmt_nxt = base + PW'(1);
                    commit     = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    state_nxt = ACCEPT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            wr_cmt <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            wr_cmt <= wr_cmt_nxt;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem[waddr] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    assign rd_entry = mem[rd_ptr[AW-1:0]];
    assign o_val    = (rd_ptr != wr_cmt);
    assign o_sop    = rd_entry.sop;
    assign o_eop    = rd_entry.eop;
    assign o_vbc    = rd_entry.vbc;
    assign o_data   = rd_entry.data;
    assign rd_fire  = o_val & o_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (rd_fire) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q <= '0;
        end else begin
            case ({commit, rd_fire & o_eop})
                2'b10:   pkt_cnt_q <= pkt_cnt_q + PW'(1);
                2'b01:   pkt_cnt_q <= pkt_cnt_q - PW'(1);
                default: pkt_cnt_q <= pkt_cnt_q;
            endcase
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign occupancy = wr_ptr - rd_ptr;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef EGRESS_STATS_EN
    logic [CNT_SIZE_P-1:0] drop_cnt_q;
    logic [CNT_SIZE_P-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (drop_inc && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + CNT_SIZE_P'(1);
            end
            if (err_inc && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + CNT_SIZE_P'(1);
            end
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign err_cnt  = err_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = &{1'b0, drop_inc, err_inc};
    assign drop_cnt     = '0;
    assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_port_egress_buffer.sv
// Randomized and directed bench for port_egress_buffer with a packet-level reference model.
// Latency: model predicts each edge; DUT state compared 1 time unit after every rising edge.
// Backpressure: o_rdy driven fixed or random; replayed chunks checked by an independent monitor.

module tb_port_egress_buffer;

    localparam int DEPTH   = 16;
    localparam int CNT_W   = 8;
    localparam int PW      = $clog2(DEPTH) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef EGRESS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic         sop;
        logic         eop;
        logic [7:0]   vbc;
        logic [255:0] data;
    } entry_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           i_val, i_sop, i_eop;
    logic [7:0]     i_vbc;
    logic [255:0]   i_data;
    logic           o_val, o_sop, o_eop;
    logic [7:0]     o_vbc;
    logic [255:0]   o_data;
    logic           o_rdy;
    logic [PW-1:0]  pkt_cnt, occupancy;
    logic [CNT_W-1:0] drop_cnt, err_cnt;

    port_egress_buffer #(.DEPTH(DEPTH), .CNT_SIZE_P(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop), .i_vbc(i_vbc), .i_data(i_data),
        .o_val(o_val), .o_sop(o_sop), .o_eop(o_eop), .o_vbc(o_vbc), .o_data(o_data),
        .o_rdy(o_rdy),
        .pkt_cnt(pkt_cnt), .occupancy(occupancy), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int out_cnt  = 0;
    bit chk_en   = 1'b0;

    // Reference model: packet-level view of the buffer
    entry_t exp_q[$];   // chunks the monitor must see, in order
    entry_t mq[$];      // committed, not yet read
    entry_t pend[$];    // current packet, not yet committed
    int     mstate = 0; // 0 idle, 1 collecting a packet, 2 discarding a packet
    int     pkts   = 0;
    int     drops  = 0;
    int     errs   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_commit();
        foreach (pend[k]) begin
            mq.push_back(pend[k]);
            exp_q.push_back(pend[k]);
        end
        pend.delete();
        pkts++;
    endtask

    task automatic model_sop(input entry_t en);
        if (mq.size() + pend.size() == DEPTH) begin
            drops  = sat_inc(drops);
            mstate = en.eop ? 0 : 2;
        end else begin
            pend.push_back(en);
            if (en.eop) begin
                model_commit();
                mstate = 0;
            end else begin
                mstate = 1;
            end
        end
    endtask

    task automatic model_step(input bit v, input entry_t en, input bit rdy, input bit rst);
        bit     rd;
        bit     full;
        entry_t head;
        if (rst) begin
            exp_q.delete(); mq.delete(); pend.delete();
            mstate = 0; pkts = 0; drops = 0; errs = 0;
            return;
        end
        rd   = rdy && (mq.size() > 0);
        full = (mq.size() + pend.size()) == DEPTH;
        if (v) begin
            case (mstate)
                0: begin
                    if (en.sop) model_sop(en);
                    else errs = sat_inc(errs);
                end
                1: begin
                    if (en.sop) begin
                        errs = sat_inc(errs);
                        pend.delete();
                        model_sop(en);
                    end else if (full) begin
                        pend.delete();
                        drops  = sat_inc(drops);
                        mstate = en.eop ? 0 : 2;
                    end else begin
                        pend.push_back(en);
                        if (en.eop) begin
                            model_commit();
                            mstate = 0;
                        end
                    end
                end
                default: begin
                    if (en.sop) begin
                        errs = sat_inc(errs);
                        model_sop(en);
                    end else if (en.eop) begin
                        mstate = 0;
                    end
                end
            endcase
        end
        if (rd) begin
            head = mq.pop_front();
            if (head.eop) pkts--;
        end
    endtask

    task automatic check_state();
        chk("o_val",     64'(o_val),     64'(mq.size() > 0));
        chk("pkt_cnt",   64'(pkt_cnt),   64'(pkts));
        chk("occupancy", 64'(occupancy), 64'(mq.size() + pend.size()));
        chk("drop_cnt",  64'(drop_cnt),  STATS ? 64'(drops) : 64'd0);
        chk("err_cnt",   64'(err_cnt),   STATS ? 64'(errs)  : 64'd0);
    endtask

    // One clock cycle: check settled state, drive inputs, predict, advance.
    task automatic cyc(input bit v, input bit s, input bit e, input logic [7:0] vbc,
                       input bit rdy, input bit rst);
        entry_t en;
        if (chk_en) check_state();
        en.sop = s; en.eop = e; en.vbc = vbc;
        for (int k = 0; k < 8; k++) en.data[k*32 +: 32] = $urandom();
        i_val = v; i_sop = s; i_eop = e; i_vbc = vbc; i_data = en.data;
        o_rdy = rdy; reset = rst;
        model_step(v, en, rdy, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 8'd0, rdy, 1'b0);
    endtask

    // rmode: 0 = o_rdy low, 1 = o_rdy high, 2 = random
    task automatic send_pkt(input int len, input logic [7:0] last_vbc, input int rmode);
        bit rdy;
        for (int k = 0; k < len; k++) begin
            rdy = (rmode == 2) ? ($urandom_range(0, 9) < 7) : (rmode == 1);
            cyc(1'b1, k == 0, k == len - 1, (k == len - 1) ? last_vbc : 8'd32, rdy, 1'b0);
        end
    endtask

    // Monitor: compares every replay handshake against the scoreboard
    always @(negedge clk) begin
        if (chk_en && !reset && o_val && o_rdy) begin
            entry_t got, want;
            out_cnt++;
            checks++;
            got = '{sop: o_sop, eop: o_eop, vbc: o_vbc, data: o_data};
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected sop=%0d eop=%0d vbc=%0d required=none t=%0t",
                         o_sop, o_eop, o_vbc, $time);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL out_chunk sop=%0d eop=%0d vbc=%0d data=%h required sop=%0d eop=%0d vbc=%0d data=%h",
                             got.sop, got.eop, got.vbc, got.data[31:0],
                             want.sop, want.eop, want.vbc, want.data[31:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_out;
        int kind;
        i_val = 0; i_sop = 0; i_eop = 0; i_vbc = 0; i_data = '0; o_rdy = 0; reset = 1;

        do_reset();
        chk_en = 1'b1;
        chk("rst_o_val", 64'(o_val), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);

        // 3-chunk packet, consumer always ready
        base_out = out_cnt;
        send_pkt(3, 8'd5, 1);
        chk("s1_o_val_after_eop", 64'(o_val), 64'd1);
        chk("s1_pkt_cnt_after_eop", 64'(pkt_cnt), 64'd1);
        idle(5, 1'b1);
        chk("s1_chunks_out", 64'(out_cnt - base_out), 64'd3);
        chk("s1_pkt_cnt_drained", 64'(pkt_cnt), 64'd0);

        // Fill with four 4-chunk packets, fifth packet dropped
        do_reset();
        for (int p = 0; p < 4; p++) send_pkt(4, 8'd32, 0);
        send_pkt(2, 8'd17, 0);
        idle(1, 1'b0);
        chk("s2_occupancy", 64'(occupancy), 64'd16);
        chk("s2_pkt_cnt", 64'(pkt_cnt), 64'd4);
        chk("s2_drop_cnt", 64'(drop_cnt), STATS ? 64'd1 : 64'd0);
        base_out = out_cnt;
        idle(20, 1'b1);
        chk("s2_chunks_out", 64'(out_cnt - base_out), 64'd16);

        // Overflow mid-packet rewinds to the committed pointer
        do_reset();
        for (int p = 0; p < 7; p++) send_pkt(2, 8'd9, 0);
        chk("s3_occupancy_pre", 64'(occupancy), 64'd14);
        send_pkt(3, 8'd3, 0);
        chk("s3_occupancy_rewound", 64'(occupancy), 64'd14);
        chk("s3_drop_cnt", 64'(drop_cnt), STATS ? 64'd1 : 64'd0);
        send_pkt(2, 8'd1, 0);
        chk("s3_occupancy_full", 64'(occupancy), 64'd16);
        chk("s3_pkt_cnt", 64'(pkt_cnt), 64'd8);
        idle(20, 1'b1);

        // Missing eop, then a single-chunk packet
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 8'd32, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'd32, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'd7,  1'b0, 1'b0);
        chk("s4_err_cnt", 64'(err_cnt), STATS ? 64'd1 : 64'd0);
        chk("s4_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("s4_occupancy", 64'(occupancy), 64'd1);
        base_out = out_cnt;
        idle(4, 1'b1);
        chk("s4_chunks_out", 64'(out_cnt - base_out), 64'd1);

        // Chunk without sop while idle
        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 8'd4, 1'b1, 1'b0);
        chk("s5_err_cnt", 64'(err_cnt), STATS ? 64'd1 : 64'd0);
        chk("s5_occupancy", 64'(occupancy), 64'd0);

        // Reset during the second chunk with a committed packet held
        do_reset();
        send_pkt(1, 8'd12, 0);
        cyc(1'b1, 1'b1, 1'b0, 8'd32, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'd32, 1'b0, 1'b1);
        chk("s6_o_val", 64'(o_val), 64'd0);
        chk("s6_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("s6_occupancy", 64'(occupancy), 64'd0);
        chk("s6_err_cnt", 64'(err_cnt), 64'd0);
        base_out = out_cnt;
        send_pkt(2, 8'd20, 1);
        idle(4, 1'b1);
        chk("s6_fresh_chunks_out", 64'(out_cnt - base_out), 64'd2);

        // Randomized traffic with protocol faults and random backpressure
        do_reset();
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 19);
            if (kind < 16) begin
                send_pkt($urandom_range(1, 6), 8'($urandom_range(1, 32)), 2);
            end else if (kind < 18) begin
                for (int k = 0; k < $urandom_range(1, 3); k++)
                    cyc(1'b1, k == 0, 1'b0, 8'd32, $urandom_range(0, 9) < 7, 1'b0);
            end else begin
                cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'd32, $urandom_range(0, 9) < 7, 1'b0);
            end
            idle($urandom_range(0, 2), $urandom_range(0, 9) < 5);
        end
        idle(40, 1'b1);
        chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("final_o_val", 64'(o_val), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
